conv_addr_gen: RTL and testbench

Parametrised convolution address generator for the CNN datapath. It walks a multi-channel input feature map with a runtime-configured kernel size and stride. For every kernel tap it emits an input-image read address, a weight read address and the output write address, using a valid/ready handshake so the MAC pipeline can stall it. Per-window first/last flags mark dot-product boundaries, and the output feature-map dimensions are reported on completion.

---
 rtl/conv_addr_gen.sv | 273 +++++++++++++++++++++++++++
 tb/tb_conv_addr_gen.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_addr_gen.sv
// conv_addr_gen: convolution address generator for the CNN datapath.
// Walks oy -> ox -> channel -> ky -> kx and emits one tap per accepted
// handshake. It produces the input-image, weight and output-window addresses
// from running base registers, using additions only. The multiplies are done
// once, in SETUP.
// Optional build macro: CONV_PAD_EN adds a zero-padding border. It adds the
// pad input and the pad_tap output.
module conv_addr_gen #(
  parameter int ADDR_W   = 19,
  parameter int DIM_W    = 10,
  parameter int CH_W     = 4,
  parameter int STRIDE_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [STRIDE_W-1:0] stride,
  input  logic [DIM_W-1:0]    w1,
  input  logic [DIM_W-1:0]    h1,
  input  logic [DIM_W-1:0]    w2,
  input  logic [DIM_W-1:0]    h2,
  input  logic [CH_W-1:0]     channels,
`ifdef CONV_PAD_EN
  input  logic [1:0]          pad,
  output logic                pad_tap,
`endif
  output logic [ADDR_W-1:0]   addr_in,
  output logic [ADDR_W-1:0]   addr_w,
  output logic [ADDR_W-1:0]   addr_out,
  output logic                tap_valid,
  input  logic                tap_ready,
  output logic                first,
  output logic                last,
  output logic                busy,
  output logic                done,
  output logic                cfg_err,
  output logic [DIM_W-1:0]    out_width,
  output logic [DIM_W-1:0]    out_height
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Coordinates are kept in the padded frame (origin at the padded corner),
  // so they never go negative. Three extra bits cover 2*pad plus stride headroom.
  localparam int CW = DIM_W + 3;

  logic [1:0]          state_q, state_d;
  logic [STRIDE_W-1:0] stride_q;
  logic [DIM_W-1:0]    w1_q, h1_q, w2_q, h2_q;
  logic [CH_W-1:0]     ch_q;
  logic [1:0]          pad_cfg;

  logic [ADDR_W-1:0]   plane_q, ksize_q, rowstep_q;
  logic [DIM_W-1:0]    kx_q, ky_q;
  logic [CH_W-1:0]     c_q;
  logic [CW-1:0]       oxp_q, oyp_q;

  // Input address bases: window row, window, channel, kernel row, tap.
  logic [ADDR_W-1:0]   in_wrow_q, in_win_q, in_ch_q, in_row_q, in_lin_q;
  // Weight address bases: channel, kernel row, tap.
  logic [ADDR_W-1:0]   w_ch_q, w_row_q, w_lin_q;
  logic [ADDR_W-1:0]   out_q;
  logic [DIM_W-1:0]    col_cnt_q, row_cnt_q, out_w_q, out_h_q;

`ifdef CONV_PAD_EN
  logic [1:0] pad_q;
  assign pad_cfg = pad_q;
`else
  assign pad_cfg = 2'd0;
`endif

  logic [CW-1:0]     w1_pad, h1_pad;
  logic              cfg_bad;
  logic [ADDR_W-1:0] plane_calc, ksize_calc, rowstep_calc, pad_off, init_base;
  logic [ADDR_W-1:0] stride_a;
  logic              last_kx, last_ky, last_c, win_end, col_adv, row_adv, hs, final_tap;

  assign w1_pad  = CW'(w1_q) + CW'({pad_cfg, 1'b0});
  assign h1_pad  = CW'(h1_q) + CW'({pad_cfg, 1'b0});
  assign cfg_bad = (stride_q == '0) || (ch_q == '0) || (w2_q == '0) || (h2_q == '0) ||
                   (CW'(w2_q) > w1_pad) || (CW'(h2_q) > h1_pad);

  // One-time products for SETUP. They are evaluated modulo 2^ADDR_W, as the addresses are.
  assign plane_calc   = ADDR_W'(w1_q) * ADDR_W'(h1_q);
  assign ksize_calc   = ADDR_W'(w2_q) * ADDR_W'(h2_q);
  assign rowstep_calc = ADDR_W'(stride_q) * ADDR_W'(w1_q);
  assign pad_off      = ADDR_W'(pad_cfg) * (ADDR_W'(w1_q) + ADDR_W'(1));
  // The first tap sits at image coordinate (-pad,-pad). Its linear address wraps
  // below zero, but it is masked until the walk enters the image.
  assign init_base    = ADDR_W'(0) - pad_off;
  assign stride_a     = ADDR_W'(stride_q);

  assign last_kx   = (kx_q == w2_q - DIM_W'(1));
  assign last_ky   = (ky_q == h2_q - DIM_W'(1));
  assign last_c    = (c_q == ch_q - CH_W'(1));
  assign win_end   = last_kx && last_ky && last_c;
  assign col_adv   = (oxp_q + CW'(stride_q) + CW'(w2_q)) <= w1_pad;
  assign row_adv   = (oyp_q + CW'(stride_q) + CW'(h2_q)) <= h1_pad;
  assign hs        = (state_q == RUN) && tap_ready;
  assign final_tap = hs && win_end && !col_adv && !row_adv;

  // Next-state logic for the IDLE/SETUP/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   state_d = cfg_bad ? IDLE : RUN;
      RUN:     if (final_tap) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Capture the configuration on an accepted start so the inputs may change afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stride_q <= '0;
      w1_q     <= '0;
      h1_q     <= '0;
      w2_q     <= '0;
      h2_q     <= '0;
      ch_q     <= '0;
`ifdef CONV_PAD_EN
      pad_q    <= '0;
`endif
    end else if (state_q == IDLE && start) begin
      stride_q <= stride;
      w1_q     <= w1;
      h1_q     <= h1;
      w2_q     <= w2;
      h2_q     <= h2;
      ch_q     <= channels;
`ifdef CONV_PAD_EN
      pad_q    <= pad;
`endif
    end
  end

  // Loop counters and running address bases. They are initialised in SETUP
  // and advanced once per accepted tap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      plane_q   <= '0;
      ksize_q   <= '0;
      rowstep_q <= '0;
      kx_q      <= '0;
      ky_q      <= '0;
      c_q       <= '0;
      oxp_q     <= '0;
      oyp_q     <= '0;
      in_wrow_q <= '0;
      in_win_q  <= '0;
      in_ch_q   <= '0;
      in_row_q  <= '0;
      in_lin_q  <= '0;
      w_ch_q    <= '0;
      w_row_q   <= '0;
      w_lin_q   <= '0;
      out_q     <= '0;
      col_cnt_q <= '0;
      row_cnt_q <= '0;
      out_w_q   <= '0;
      out_h_q   <= '0;
    end else if (state_q == SETUP) begin
      plane_q   <= plane_calc;
      ksize_q   <= ksize_calc;
      rowstep_q <= rowstep_calc;
      kx_q      <= '0;
      ky_q      <= '0;
      c_q       <= '0;
      oxp_q     <= '0;
      oyp_q     <= '0;
      in_wrow_q <= init_base;
      in_win_q  <= init_base;
      in_ch_q   <= init_base;
      in_row_q  <= init_base;
      in_lin_q  <= init_base;
      w_ch_q    <= '0;
      w_row_q   <= '0;
      w_lin_q   <= '0;
      out_q     <= '0;
      col_cnt_q <= DIM_W'(1);
      row_cnt_q <= DIM_W'(1);
    end else if (hs) begin
      if (!last_kx) begin
        kx_q     <= kx_q + DIM_W'(1);
        in_lin_q <= in_lin_q + ADDR_W'(1);
        w_lin_q  <= w_lin_q + ADDR_W'(1);
      end else if (!last_ky) begin
        kx_q     <= '0;
        ky_q     <= ky_q + DIM_W'(1);
        in_row_q <= in_row_q + ADDR_W'(w1_q);
        in_lin_q <= in_row_q + ADDR_W'(w1_q);
        w_row_q  <= w_row_q + ADDR_W'(w2_q);
        w_lin_q  <= w_row_q + ADDR_W'(w2_q);
      end else if (!last_c) begin
        kx_q     <= '0;
        ky_q     <= '0;
        c_q      <= c_q + CH_W'(1);
        in_ch_q  <= in_ch_q + plane_q;
        in_row_q <= in_ch_q + plane_q;
        in_lin_q <= in_ch_q + plane_q;
        w_ch_q   <= w_ch_q + ksize_q;
        w_row_q  <= w_ch_q + ksize_q;
        w_lin_q  <= w_ch_q + ksize_q;
      end else begin
        // Window complete: rewind the kernel walk and step to the next window.
        kx_q    <= '0;
        ky_q    <= '0;
        c_q     <= '0;
        w_ch_q  <= '0;
        w_row_q <= '0;
        w_lin_q <= '0;
        out_q   <= out_q + ADDR_W'(1);
        if (col_adv) begin
          oxp_q     <= oxp_q + CW'(stride_q);
          in_win_q  <= in_win_q + stride_a;
          in_ch_q   <= in_win_q + stride_a;
          in_row_q  <= in_win_q + stride_a;
          in_lin_q  <= in_win_q + stride_a;
          col_cnt_q <= col_cnt_q + DIM_W'(1);
        end else if (row_adv) begin
          oxp_q     <= '0;
          oyp_q     <= oyp_q + CW'(stride_q);
          in_wrow_q <= in_wrow_q + rowstep_q;
          in_win_q  <= in_wrow_q + rowstep_q;
          in_ch_q   <= in_wrow_q + rowstep_q;
          in_row_q  <= in_wrow_q + rowstep_q;
          in_lin_q  <= in_wrow_q + rowstep_q;
          col_cnt_q <= DIM_W'(1);
          row_cnt_q <= row_cnt_q + DIM_W'(1);
        end else begin
          // All rows have the same number of windows, so the last row's count is the width.
          out_w_q <= col_cnt_q;
          out_h_q <= row_cnt_q;
        end
      end
    end
  end

`ifdef CONV_PAD_EN
  logic [CW-1:0] col_p, row_p;
  logic          outside;
  assign col_p   = oxp_q + CW'(kx_q);
  assign row_p   = oyp_q + CW'(ky_q);
  assign outside = (col_p < CW'(pad_cfg)) || (col_p >= CW'(w1_q) + CW'(pad_cfg)) ||
                   (row_p < CW'(pad_cfg)) || (row_p >= CW'(h1_q) + CW'(pad_cfg));
  assign pad_tap = tap_valid && outside;
  assign addr_in = outside ? '0 : in_lin_q;
`else
  assign addr_in = in_lin_q;
`endif

  assign addr_w     = w_lin_q;
  assign addr_out   = out_q;
  assign tap_valid  = (state_q == RUN);
  assign first      = tap_valid && (kx_q == '0) && (ky_q == '0) && (c_q == '0);
  assign last       = tap_valid && win_end;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign cfg_err    = (state_q == SETUP) && cfg_bad;
  assign out_width  = out_w_q;
  assign out_height = out_h_q;

endmodule

// File: tb/tb_conv_addr_gen.sv
// Directed bench for conv_addr_gen. A configuration table is run through a
// loop, and every tap is compared with a nested-loop reference. Hand-written
// sequences cover backpressure, start-while-busy and mid-run reset. The padding
// case is compiled in when CONV_PAD_EN is defined.
`timescale 1ns/1ps
module tb_conv_addr_gen;
  localparam int ADDR_W   = 19;
  localparam int DIM_W    = 10;
  localparam int CH_W     = 4;
  localparam int STRIDE_W = 5;
  localparam int NV       = 10;

  typedef struct {
    string name;
    int    stride, w1, h1, w2, h2, ch, pad;
    int    exp_taps, exp_ow, exp_oh;
    bit    exp_err;
  } vec_t;

  logic                clk = 1'b0;
  logic                reset, start, tap_ready;
  logic [STRIDE_W-1:0] stride;
  logic [DIM_W-1:0]    w1, h1, w2, h2;
  logic [CH_W-1:0]     channels;
  logic [ADDR_W-1:0]   addr_in, addr_w, addr_out;
  logic                tap_valid, first, last, busy, done, cfg_err;
  logic [DIM_W-1:0]    out_width, out_height;
  logic                pad_tap_w;
`ifdef CONV_PAD_EN
  logic [1:0]          pad_s;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  int m_in[$], m_w[$], m_out[$];
  bit m_first[$], m_last[$], m_pad[$];
  int d_in[$], d_w[$], d_out[$];
  bit d_last[$], d_pad[$];

  vec_t vecs[NV];

  conv_addr_gen #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .CH_W(CH_W), .STRIDE_W(STRIDE_W)) dut (
    .clk(clk), .reset(reset), .start(start), .stride(stride),
    .w1(w1), .h1(h1), .w2(w2), .h2(h2), .channels(channels),
`ifdef CONV_PAD_EN
    .pad(pad_s), .pad_tap(pad_tap_w),
`endif
    .addr_in(addr_in), .addr_w(addr_w), .addr_out(addr_out),
    .tap_valid(tap_valid), .tap_ready(tap_ready), .first(first), .last(last),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .out_width(out_width), .out_height(out_height)
  );

`ifndef CONV_PAD_EN
  assign pad_tap_w = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string what, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", what, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input int s, input int a, input int b,
                              input int c, input int d, input int ch, input int p,
                              input int taps, input int ow, input int oh, input bit err);
    vec_t v;
    v.name = nm; v.stride = s; v.w1 = a; v.h1 = b; v.w2 = c; v.h2 = d; v.ch = ch; v.pad = p;
    v.exp_taps = taps; v.exp_ow = ow; v.exp_oh = oh; v.exp_err = err;
    return v;
  endfunction

  function automatic logic [63:0] tuple_now();
    return {4'b0, addr_in, addr_w, addr_out, first, last, pad_tap_w};
  endfunction

  function automatic int qget(input int q[$], input int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  // Reference walk straight from the address formulas (with multiplies).
  task automatic build_model(input vec_t v);
    int wp, hp, win, r, col;
    bit p;
    m_in.delete(); m_w.delete(); m_out.delete();
    m_first.delete(); m_last.delete(); m_pad.delete();
    if (v.exp_err) return;
    wp = v.w1 + 2 * v.pad;
    hp = v.h1 + 2 * v.pad;
    win = 0;
    for (int oy = 0; oy + v.h2 <= hp; oy += v.stride)
      for (int ox = 0; ox + v.w2 <= wp; ox += v.stride) begin
        for (int c = 0; c < v.ch; c++)
          for (int ky = 0; ky < v.h2; ky++)
            for (int kx = 0; kx < v.w2; kx++) begin
              r   = oy + ky - v.pad;
              col = ox + kx - v.pad;
              p   = (r < 0) || (r >= v.h1) || (col < 0) || (col >= v.w1);
              m_in.push_back(p ? 0 : c * v.w1 * v.h1 + r * v.w1 + col);
              m_w.push_back(c * v.w2 * v.h2 + ky * v.w2 + kx);
              m_out.push_back(win);
              m_first.push_back(c == 0 && ky == 0 && kx == 0);
              m_last.push_back(c == v.ch - 1 && ky == v.h2 - 1 && kx == v.w2 - 1);
              m_pad.push_back(p);
            end
        win++;
      end
  endtask

  task automatic drive_cfg(input vec_t v);
    stride   = STRIDE_W'(v.stride);
    w1       = DIM_W'(v.w1);
    h1       = DIM_W'(v.h1);
    w2       = DIM_W'(v.w2);
    h2       = DIM_W'(v.h2);
    channels = CH_W'(v.ch);
`ifdef CONV_PAD_EN
    pad_s    = 2'(v.pad);
`endif
  endtask

  task automatic run_vec(input vec_t v, input bit stall, input bit poke);
    int n, last_hs, errs, cyc;
    bit got_done, held, poked;
    logic [63:0] held_t, cur_t, exp_t;
    build_model(v);
    d_in.delete(); d_w.delete(); d_out.delete(); d_last.delete(); d_pad.delete();
    n = 0; last_hs = -100; errs = 0; got_done = 0; held = 0; poked = 0; held_t = '0;
    @(negedge clk);
    drive_cfg(v);
    start = 1'b1;
    tap_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble the inputs: the run must use only the captured configuration.
    stride = '1; w1 = '1; h1 = '1; w2 = DIM_W'(1); h2 = DIM_W'(1); channels = '1;
    check({v.name, "/busy_in_setup"}, busy, 1);
    check({v.name, "/cfg_err_in_setup"}, cfg_err, v.exp_err);
    for (cyc = 0; cyc < 3000; cyc++) begin
      cur_t = tuple_now();
      if (cfg_err) errs++;
      if (done) begin
        got_done = 1;
        break;
      end
      if (cyc == 0) check({v.name, "/no_valid_in_setup"}, tap_valid, 0);
      if (cyc == 1 && !v.exp_err) check({v.name, "/first_valid"}, tap_valid, 1);
      if (held) check({v.name, "/stall_hold"}, {tap_valid, cur_t[62:0]}, {1'b1, held_t[62:0]});
      start = 1'b0;
      if (poke && !poked && n == 5) begin
        start = 1'b1;
        poked = 1;
      end
      tap_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      held = 0;
      if (tap_valid) begin
        if (tap_ready) begin
          if (n < m_in.size())
            exp_t = {4'b0, ADDR_W'(m_in[n]), ADDR_W'(m_w[n]), ADDR_W'(m_out[n]),
                     m_first[n], m_last[n], m_pad[n]};
          else
            exp_t = '1;
          check($sformatf("%s/tap%0d", v.name, n), cur_t, exp_t);
          d_in.push_back(int'(addr_in));
          d_w.push_back(int'(addr_w));
          d_out.push_back(int'(addr_out));
          d_last.push_back(last);
          d_pad.push_back(pad_tap_w);
          n++;
          last_hs = cyc;
        end else begin
          held = 1;
          held_t = cur_t;
        end
      end
      if (v.exp_err && cyc >= 4) break;
      @(negedge clk);
    end
    start = 1'b0;
    check({v.name, "/tap_count"}, n, v.exp_taps);
    check({v.name, "/cfg_err_pulses"}, errs, v.exp_err ? 1 : 0);
    if (v.exp_err) begin
      check({v.name, "/no_done"}, got_done, 0);
    end else begin
      check({v.name, "/done_seen"}, got_done, 1);
      if (got_done) begin
        check({v.name, "/done_latency"}, cyc - last_hs, 1);
        check({v.name, "/busy_with_done"}, busy, 1);
        check({v.name, "/out_width"}, out_width, v.exp_ow);
        check({v.name, "/out_height"}, out_height, v.exp_oh);
        @(negedge clk);
        check({v.name, "/idle_after_done"}, {busy, done}, 0);
        check({v.name, "/out_width_hold"}, out_width, v.exp_ow);
      end
    end
    $display("run %s stall=%0d: %0d taps, out %0dx%0d, done=%0d, cfg_err pulses=%0d",
             v.name, stall, n, out_width, out_height, got_done, errs);
  endtask

  initial begin : main
    int bx[8];
    int mx[8];
    int n, pc;
    reset = 1'b0; start = 1'b0; tap_ready = 1'b0;
    stride = '0; w1 = '0; h1 = '0; w2 = '0; h2 = '0; channels = '0;
`ifdef CONV_PAD_EN
    pad_s = '0;
`endif
    repeat (3) @(negedge clk);
    check("reset/addrs", {addr_in, addr_w, addr_out}, 0);
    check("reset/ctrl", {tap_valid, first, last, busy, done, cfg_err, pad_tap_w}, 0);
    check("reset/out_size", {out_width, out_height}, 0);
    reset = 1'b1;

    vecs[0] = mk("basic",    1, 4, 4, 2, 2, 1, 0, 36, 3, 3, 0);
    vecs[1] = mk("stride2",  2, 5, 5, 3, 3, 1, 0, 36, 2, 2, 0);
    vecs[2] = mk("multich",  1, 3, 3, 2, 2, 2, 0, 32, 2, 2, 0);
    vecs[3] = mk("rect",     1, 6, 3, 3, 2, 3, 0, 144, 4, 2, 0);
    vecs[4] = mk("stride3",  3, 7, 5, 2, 2, 1, 0, 16, 2, 2, 0);
    vecs[5] = mk("kfull",    1, 3, 3, 3, 3, 1, 0, 9, 1, 1, 0);
    vecs[6] = mk("err_s0",   0, 4, 4, 2, 2, 1, 0, 0, 0, 0, 1);
    vecs[7] = mk("err_ch0",  1, 4, 4, 2, 2, 0, 0, 0, 0, 0, 1);
    vecs[8] = mk("err_wide", 1, 3, 4, 4, 2, 1, 0, 0, 0, 0, 1);
    vecs[9] = mk("err_h0",   1, 4, 4, 2, 0, 1, 0, 0, 0, 0, 1);

    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], 1'b0, 1'b0);
      case (i)
        0: begin
          bx = '{0, 1, 4, 5, 1, 2, 5, 6};
          for (int k = 0; k < 8; k++) check($sformatf("basic/addr_in%0d", k), qget(d_in, k), bx[k]);
          for (int k = 0; k < 9; k++) check($sformatf("basic/addr_out_win%0d", k), qget(d_out, 4 * k), k);
        end
        1: begin
          bx[0] = 0; bx[1] = 2; bx[2] = 10; bx[3] = 12;
          for (int k = 0; k < 4; k++) check($sformatf("stride2/win%0d_first_in", k), qget(d_in, 9 * k), bx[k]);
        end
        2: begin
          mx = '{0, 1, 3, 4, 9, 10, 12, 13};
          for (int k = 0; k < 8; k++) begin
            check($sformatf("multich/addr_in%0d", k), qget(d_in, k), mx[k]);
            check($sformatf("multich/addr_w%0d", k), qget(d_w, k), k);
            check($sformatf("multich/last%0d", k), (k < d_last.size()) ? d_last[k] : 1'bx, k == 7);
          end
        end
        default: ;
      endcase
    end

    // Random backpressure with a start pulse while busy: it must be ignored.
    run_vec(vecs[0], 1'b1, 1'b1);

    // Mid-run reset after ten handshakes.
    @(negedge clk);
    drive_cfg(vecs[0]);
    start = 1'b1;
    tap_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (tap_valid && tap_ready) n++;
      if (n == 10) break;
      @(negedge clk);
    end
    check("rst/taps_before_reset", n, 10);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst/addrs", {addr_in, addr_w, addr_out}, 0);
    check("rst/ctrl", {tap_valid, first, last, busy, done, cfg_err, pad_tap_w}, 0);
    check("rst/out_size", {out_width, out_height}, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst/no_done_held", {done, busy, tap_valid}, 0);
    end
    reset = 1'b1;
    @(negedge clk);
    check("rst/idle_after_release", {done, busy, tap_valid}, 0);
    run_vec(vecs[0], 1'b0, 1'b0);
    check("rst/rerun_first_in", qget(d_in, 0), 0);

`ifdef CONV_PAD_EN
    begin : pad_case
      vec_t pv;
      pv = mk("pad1", 1, 3, 3, 3, 3, 1, 1, 81, 3, 3, 0);
      run_vec(pv, 1'b0, 1'b0);
      pc = 0;
      for (int k = 0; k < 9 && k < d_pad.size(); k++) pc += int'(d_pad[k]);
      check("pad1/win0_pad_taps", pc, 5);
      check("pad1/centre_addr_in", qget(d_in, 4), 0);
      check("pad1/centre_pad_tap", (d_pad.size() > 4) ? d_pad[4] : 1'b1, 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
